// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for common-anode 7-segment digits sharing one
// registered seg7_encoder; double-buffered display word swapped on frame edges.

module seg7_scan_lane (
    input  logic [3:0] nib,
    input  logic       zero_hi,
    input  logic       blank_lz,
    output logic       zero_here,
    output logic       blank
);
    // zero_here: this nibble and every more significant one are zero
    assign zero_here = zero_hi && (nib == 4'd0);
    assign blank     = blank_lz && zero_here;
endmodule

module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 50000,
    parameter int DEAD_CYC   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic [3:0]              digit_num,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    dp_n,
    output logic                    frame_start
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {ST_DEAD, ST_DRIVE} state_t;

    state_t                       state;
    logic [CNT_W-1:0]             cnt, cnt_nxt;
    logic [IDX_W-1:0]             idx;
    logic [NUM_DIGITS-1:0][3:0]   active_nib, shadow_nib;
    logic [NUM_DIGITS-1:0]        active_dp, shadow_dp;
    logic                         pending;
    logic                         slot_end, frame_end, xfer, drive;
    logic [NUM_DIGITS-1:0]        blank;
    logic [NUM_DIGITS:1]          zero_from;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
    assign xfer      = load_valid && load_ready;

    // Digit 0 is never blanked, so the blanking chain only covers digits 1..N-1
    assign zero_from[NUM_DIGITS] = 1'b1;
    assign blank[0]              = 1'b0;
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lane
        seg7_scan_lane u_lane (
            .nib       (active_nib[i]),
            .zero_hi   (zero_from[i+1]),
            .blank_lz  (blank_lz),
            .zero_here (zero_from[i]),
            .blank     (blank[i])
        );
    end

    // Slot timing; state tracks cnt so it is DEAD exactly while cnt < DEAD_CYC
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            state <= ST_DEAD;
        end else begin
            cnt <= cnt_nxt;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            state <= (cnt_nxt >= DEAD_END) ? ST_DRIVE : ST_DEAD;
        end
    end

    // Shadow load and frame-boundary swap; pending implies !load_ready, so
    // a transfer can never coincide with a swap.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_nib  <= '0;
            active_dp   <= '0;
            shadow_nib  <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
            load_ready  <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if (frame_end && pending) begin
                active_nib <= shadow_nib;
                active_dp  <= shadow_dp;
                pending    <= 1'b0;
                load_ready <= 1'b1;
            end else if (xfer) begin
                shadow_nib <= load_data;
                shadow_dp  <= load_dp;
                pending    <= 1'b1;
                load_ready <= 1'b0;
            end
        end
    end

    assign drive = (state == ST_DRIVE) && enable && !blank[idx];

    // The encoder adds one more register after digit_num, which the dead time hides
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_num <= 4'd0;
            anode_n   <= '1;
            dp_n      <= 1'b1;
        end else begin
            digit_num <= active_nib[idx];
            if (drive) begin
                anode_n <= ~(NUM_DIGITS'(1) << idx);
                dp_n    <= ~active_dp[idx];
            end else begin
                anode_n <= '1;
                dp_n    <= 1'b1;
            end
        end
    end
endmodule
